// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit for the execute stage: WIDTH-cycle
// shift-add multiply or restoring divide, results held in HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic op_legal;
    logic op_div;
    logic op_signed;

    logic can_accept;
    logic accept;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               prod_neg;
    logic               rem_neg;
    logic               dbz_pend;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    always_comb begin
        op_legal  = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h18: begin
                    op_legal  = 1'b1;
                    op_signed = 1'b1;
                end
                6'h19: begin
                    op_legal  = 1'b1;
                end
                6'h1A: begin
                    op_legal  = 1'b1;
                    op_div    = 1'b1;
                    op_signed = 1'b1;
                end
                6'h1B: begin
                    op_legal  = 1'b1;
                    op_div    = 1'b1;
                end
                default: begin
                    op_legal  = 1'b0;
                end
            endcase
        end else if (opcode == 6'h1C && funct == 6'h02) begin
            op_legal  = 1'b1;
            op_signed = 1'b1;
        end
    end

    assign can_accept = (state != RUN);
    assign accept     = start && op_legal && can_accept;

    // The iteration works on magnitudes; signs are reapplied when the result lands.
    assign a_neg = op_signed && a[WIDTH-1];
    assign b_neg = op_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = accept ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            if (div_trial[WIDTH]) begin
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_final = prod_neg ? -acc_step : acc_step;
        quo_final  = prod_neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_final  = rem_neg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            prod_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            dbz_pend    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            illegal <= start && can_accept && !op_legal;
            if (accept) begin
                acc         <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                opnd        <= op_div ? b_mag : a_mag;
                a_raw       <= a;
                cnt         <= CNT_W'(WIDTH - 1);
                is_div      <= op_div;
                prod_neg    <= a_neg ^ b_neg;
                rem_neg     <= a_neg;
                dbz_pend    <= op_div && (b == '0);
                div_by_zero <= 1'b0;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
                if (cnt == '0) begin
                    if (!is_div) begin
                        hi <= prod_final[2*WIDTH-1:WIDTH];
                        lo <= prod_final[WIDTH-1:0];
                    end else if (dbz_pend) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_final;
                        lo <= quo_final;
                    end
                    div_by_zero <= dbz_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .opcode(opcode),
        .funct(funct),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_by_zero(div_by_zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled after the accept edge so late sampling would be visible.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start  = 1'b1;
        opcode = op;
        funct  = fn;
        a      = av;
        b      = bv;
        step();
        start  = 1'b0;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic wait_done(input int first, output int cycles, output int busy_cycles);
        cycles      = first;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 4 * LAT) begin
            if (busy === 1'b1) busy_cycles++;
            step();
            cycles++;
        end
    endtask

    task automatic ref_model(input logic [5:0] op, input logic [5:0] fn,
                             input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             output logic [WIDTH-1:0] ehi, output logic [WIDTH-1:0] elo,
                             output logic edbz);
        longint     sa;
        longint     sb;
        longint     sq;
        longint     sr;
        logic [63:0] up;
        sa   = longint'($signed(av));
        sb   = longint'($signed(bv));
        edbz = 1'b0;
        ehi  = '0;
        elo  = '0;
        if (op == 6'h1C || fn == 6'h18) begin
            up  = 64'(sa * sb);
            ehi = up[63:32];
            elo = up[31:0];
        end else if (fn == 6'h19) begin
            up  = {32'h0, av} * {32'h0, bv};
            ehi = up[63:32];
            elo = up[31:0];
        end else if (bv == '0) begin
            elo  = '1;
            ehi  = av;
            edbz = 1'b1;
        end else if (fn == 6'h1A) begin
            sq  = sa / sb;
            sr  = sa % sb;
            elo = sq[31:0];
            ehi = sr[31:0];
        end else begin
            elo = av / bv;
            ehi = av % bv;
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h19;
        a      = 32'd5;
        b      = 32'd7;
        repeat (3) step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (hi !== '0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== '0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst_n = 1'b1;
        start = 1'b0;
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", busy); end
    endtask

    task automatic test_multu();
        int cyc;
        int bcyc;
        issue(6'h00, 6'h19, 32'hFFFF_FFFF, 32'h2);
        wait_done(1, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL multu_latency: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (bcyc !== WIDTH) begin tests_failed++; $display("[TB] FAIL multu_busy_cycles: got %0d expected %0d", bcyc, WIDTH); end
        tests_run++; if (hi !== 32'h1) begin tests_failed++; $display("[TB] FAIL multu_hi: got %h expected 00000001", hi); end
        tests_run++; if (lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL multu_lo: got %h expected fffffffe", lo); end
        step();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL multu_done_pulse: got %b expected 0", done); end
        tests_run++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL multu_hold: got %h_%h expected 00000001_fffffffe", hi, lo); end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        int busy_seen;
        issue(6'h00, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        tests_run++; if (hi !== '0 || lo !== '0) begin tests_failed++; $display("[TB] FAIL midrst_hilo: got %h_%h expected 0_0", hi, lo); end
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
            step();
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
        tests_run++; if (busy_seen !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_busy: got %0d cycles expected 0", busy_seen); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bcyc;
        issue(6'h00, 6'h18, -32'sd3, 32'd7);
        wait_done(1, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL mult_latency: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
        issue(6'h00, 6'h1A, -32'sd7, 32'd2);
        tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        wait_done(1, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL div_result: got %h_%h expected ffffffff_fffffffd", hi, lo); end
        step();
    endtask

    task automatic test_div_by_zero();
        int cyc;
        int bcyc;
        issue(6'h00, 6'h1B, 32'd100, 32'd0);
        wait_done(1, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL dbz_latency: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL dbz_result: got %h_%h expected 00000064_ffffffff", hi, lo); end
        tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL dbz_flag: got %b expected 1", div_by_zero); end
        step();
        issue(6'h00, 6'h3F, 32'd1, 32'd1);
        tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL dbz_hold: got %b expected 1", div_by_zero); end
        issue(6'h00, 6'h1B, 32'd9, 32'd4);
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL dbz_clear: got %b expected 0", div_by_zero); end
        wait_done(1, cyc, bcyc);
        tests_run++; if (hi !== 32'd1 || lo !== 32'd2) begin tests_failed++; $display("[TB] FAIL divu_9_4: got %h_%h expected 00000001_00000002", hi, lo); end
        issue(6'h00, 6'h1A, -32'sd5, 32'd0);
        wait_done(1, cyc, bcyc);
        tests_run++; if (hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL sdbz_result: got %h_%h dbz=%b expected fffffffb_ffffffff dbz=1", hi, lo, div_by_zero); end
        step();
    endtask

    task automatic test_overflow();
        int cyc;
        int bcyc;
        issue(6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL ovf_latency: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (hi !== '0 || lo !== 32'h8000_0000 || div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_result: got %h_%h dbz=%b expected 00000000_80000000 dbz=0", hi, lo, div_by_zero); end
        step();
    endtask

    task automatic test_illegal();
        int cyc;
        int bcyc;
        issue(6'h00, 6'h19, 32'd6, 32'd7);
        wait_done(1, cyc, bcyc);
        tests_run++; if (hi !== '0 || lo !== 32'd42) begin tests_failed++; $display("[TB] FAIL ill_setup: got %h_%h expected 0_0000002a", hi, lo); end
        issue(6'h1C, 6'h03, 32'd3, 32'd3);
        tests_run++; if (illegal !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_in_done: got ill=%b busy=%b done=%b expected 1 0 0", illegal, busy, done); end
        step();
        tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_pulse1: got %b expected 0", illegal); end
        issue(6'h00, 6'h20, 32'd3, 32'd3);
        tests_run++; if (illegal !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_in_idle: got ill=%b busy=%b expected 1 0", illegal, busy); end
        step();
        tests_run++; if (illegal !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_pulse2: got ill=%b busy=%b expected 0 0", illegal, busy); end
        tests_run++; if (hi !== '0 || lo !== 32'd42) begin tests_failed++; $display("[TB] FAIL ill_hilo: got %h_%h expected 0_0000002a", hi, lo); end
    endtask

    task automatic test_ignored_start();
        int cyc;
        int bcyc;
        int done_seen;
        int busy_seen;
        issue(6'h00, 6'h1B, 32'd1000, 32'd7);
        repeat (3) step();
        start  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        a      = $urandom;
        b      = $urandom;
        step();
        funct = 6'h18;
        repeat (4) step();
        start = 1'b0;
        wait_done(9, cyc, bcyc);
        tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL ign_latency: got %0d expected %0d", cyc, LAT); end
        tests_run++; if (hi !== 32'd6 || lo !== 32'd142) begin tests_failed++; $display("[TB] FAIL ign_result: got %h_%h expected 00000006_0000008e", hi, lo); end
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            step();
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1 || illegal === 1'b1) busy_seen++;
        end
        tests_run++; if (done_seen !== 0 || busy_seen !== 0) begin tests_failed++; $display("[TB] FAIL ign_single_done: got done=%0d busy/ill=%0d expected 0 0", done_seen, busy_seen); end
    endtask

    task automatic test_random();
        logic [5:0]       op;
        logic [5:0]       fn;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [WIDTH-1:0] ehi;
        logic [WIDTH-1:0] elo;
        logic             edbz;
        int cyc;
        int bcyc;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       begin op = 6'h00; fn = 6'h18; end
                1:       begin op = 6'h00; fn = 6'h19; end
                2:       begin op = 6'h00; fn = 6'h1A; end
                3:       begin op = 6'h00; fn = 6'h1B; end
                default: begin op = 6'h1C; fn = 6'h02; end
            endcase
            av = pick_operand();
            bv = pick_operand();
            ref_model(op, fn, av, bv, ehi, elo, edbz);
            issue(op, fn, av, bv);
            tests_run++; if (busy !== 1'b1 || div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_accept[%0d]: got busy=%b dbz=%b expected 1 0", i, busy, div_by_zero); end
            wait_done(1, cyc, bcyc);
            tests_run++; if (cyc !== LAT) begin tests_failed++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, cyc, LAT); end
            tests_run++; if (hi !== ehi || lo !== elo) begin tests_failed++; $display("[TB] FAIL rnd_result[%0d] op=%h fn=%h a=%h b=%h: got %h_%h expected %h_%h", i, op, fn, av, bv, hi, lo, ehi, elo); end
            tests_run++; if (div_by_zero !== edbz) begin tests_failed++; $display("[TB] FAIL rnd_dbz[%0d]: got %b expected %b", i, div_by_zero, edbz); end
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = '0;
        funct  = '0;
        a      = '0;
        b      = '0;
        test_reset();
        test_multu();
        test_reset_mid_op();
        test_back_to_back();
        test_div_by_zero();
        test_overflow();
        test_illegal();
        test_ignored_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
